// File: rtl/xdisp_pkg.sv
// Shared constants, FSM state type and helpers for the xdisp_ctrl display arbiter.
package xdisp_pkg;

    localparam int unsigned N_REQ  = 4;
    localparam int unsigned DATA_W = 11;
    localparam int unsigned PTR_W  = 2;
    localparam int unsigned CNT_W  = 24;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DWELL = 1'b1
    } state_t;

    // Converts a one-hot requester vector into its index (zero when empty).
    function automatic logic [PTR_W-1:0] oh_to_idx(input logic [N_REQ-1:0] oh);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | PTR_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/xdisp_ctrl_if.sv
// Requester/display bus of xdisp_ctrl: requests and data in, grant/ack/display out.
interface xdisp_ctrl_if;
    import xdisp_pkg::*;

    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] data_in;
    logic [N_REQ-1:0]        grant;
    logic [N_REQ-1:0]        ack;
    logic [DATA_W-1:0]       disp_data;
    logic                    disp_sel;
    logic                    busy;

    modport master (
        output req, data_in,
        input  grant, ack, disp_data, disp_sel, busy
    );

    modport slave (
        input  req, data_in,
        output grant, ack, disp_data, disp_sel, busy
    );

endinterface

// File: rtl/xdisp_rr_arb.sv
// Combinational round-robin picker: search starts one past ptr and wraps.
module xdisp_rr_arb
    import xdisp_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] winner,
    output logic             valid
);

    logic [PTR_W-1:0] idx;

    // First requester found after the pointer wins; the pointer itself is tried last.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            idx = ptr + PTR_W'(i);
            if (!valid && req[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xdisp_ctrl.sv
// Display arbiter: grants one of four requesters the display for DWELL cycles,
// capturing its 11-bit value and toggling disp_sel on every capture.
// Optional macro XDISP_CTRL_PRIO_EN makes requester 0 pre-empt other owners.
module xdisp_ctrl
    import xdisp_pkg::DATA_W, xdisp_pkg::PTR_W, xdisp_pkg::CNT_W;
    import xdisp_pkg::state_t, xdisp_pkg::ST_IDLE, xdisp_pkg::ST_DWELL;
    import xdisp_pkg::oh_to_idx;
#(
    parameter int unsigned DWELL = 1000,
    parameter int unsigned N_REQ = 4
) (
    input  logic        clk,
    input  logic        rst,
    xdisp_ctrl_if.slave bus
);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [N_REQ-1:0]    grant_q, grant_d;
    logic [N_REQ-1:0]    ack_q, ack_d;
    logic [DATA_W-1:0]   disp_data_q, disp_data_d;
    logic                disp_sel_q, disp_sel_d;

    logic [N_REQ-1:0]    arb_oh;
    logic                arb_valid;
    logic                cap_en;
    logic                adv_en;
    logic [N_REQ-1:0]    cap_oh;
    logic [PTR_W-1:0]    cap_idx;
    logic [DATA_W-1:0]   slice [N_REQ];

    xdisp_rr_arb u_arb (
        .req    (bus.req),
        .ptr    (ptr_q),
        .winner (arb_oh),
        .valid  (arb_valid)
    );

    // Split the packed data bus into per-requester values.
    always_comb begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            slice[i] = bus.data_in[i*DATA_W +: DATA_W];
        end
    end

    // Next-state: arbitrate in IDLE or at dwell expiry, otherwise count down.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        ack_d       = '0;
        disp_data_d = disp_data_q;
        disp_sel_d  = disp_sel_q;
        cap_en      = 1'b0;
        adv_en      = 1'b0;
        cap_oh      = arb_oh;
        cap_idx     = '0;

        case (state_q)
            ST_IDLE: begin
                cap_en = arb_valid;
                adv_en = arb_valid;
            end
            ST_DWELL: begin
                if (cnt_q == '0) begin
                    cap_en = arb_valid;
                    adv_en = arb_valid;
                    if (!arb_valid) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
`ifdef XDISP_CTRL_PRIO_EN
                // Requester 0 overrides any other owner without moving the pointer.
                if (bus.req[0] && !grant_q[0]) begin
                    cap_en = 1'b1;
                    adv_en = 1'b0;
                    cap_oh = N_REQ'(1);
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (cap_en) begin
            cap_idx     = oh_to_idx(cap_oh);
            state_d     = ST_DWELL;
            cnt_d       = CNT_W'(DWELL - 1);
            grant_d     = cap_oh;
            ack_d       = cap_oh;
            disp_data_d = slice[cap_idx];
            disp_sel_d  = ~disp_sel_q;
            if (adv_en) begin
                ptr_d = cap_idx;
            end
        end
    end

    // State and output registers; reset points the pointer at 3 so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            ptr_q       <= PTR_W'(3);
            grant_q     <= '0;
            ack_q       <= '0;
            disp_data_q <= '0;
            disp_sel_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            ack_q       <= ack_d;
            disp_data_q <= disp_data_d;
            disp_sel_q  <= disp_sel_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.ack       = ack_q;
    assign bus.disp_data = disp_data_q;
    assign bus.disp_sel  = disp_sel_q;
    assign bus.busy      = (state_q == ST_DWELL);

endmodule

// File: doc/xdisp_ctrl.md
XDISP_CTRL -- requirements
Module: xdisp_ctrl

Interface
REQ-001 Parameter DWELL, default 1000, SHALL set the display hold time per grant in clk cycles (legal range 2..2^24-1).
REQ-002 Parameter N_REQ, default 4, SHALL set the number of requesters (fixed at 4 in this release).
REQ-003 clk  input  1  system clock; one clock domain; all outputs registered on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req  input  4  per-requester display request; bit i belongs to requester i.
REQ-006 data_in  input  44  four 11-bit two's-complement values; requester i occupies bits [11i+10:11i].
REQ-007 grant  output  4  one-hot current display owner; all zero when idle.
REQ-008 ack  output  4  one-cycle pulse on bit i when requester i's value is captured.
REQ-009 disp_data  output  11  value presented to the display driver's data_in.
REQ-010 disp_sel  output  1  display driver select; toggles once per capture, so the driver reloads.
REQ-011 busy  output  1  high while a dwell period is running.

Function
REQ-012 The FSM SHALL have two states: IDLE and DWELL.
REQ-013 In IDLE, at any edge where req is nonzero, the block SHALL choose a winner, update grant, pulse ack, load disp_data from the winner's slice, toggle disp_sel, load the dwell counter with DWELL-1 and enter DWELL, all visible in the following cycle.
REQ-014 Arbitration SHALL be round-robin: the search starts at the index after the last winner and wraps from 3 to 0.
REQ-015 The round-robin pointer SHALL advance only on a capture.
REQ-016 In DWELL, the counter SHALL decrement each cycle, and grant and disp_data SHALL hold.
REQ-017 At the edge where the counter equals 0, the block SHALL re-arbitrate as in REQ-013.
REQ-018 If req is zero at that edge, the block SHALL enter IDLE, clear grant and busy, and retain disp_data and disp_sel.
REQ-019 When the current owner is the only requester at expiry, it SHALL be re-granted and its new value captured, and disp_sel SHALL toggle.
REQ-020 With continuous requests, each owner SHALL hold the display for exactly DWELL cycles.
REQ-021 data_in SHALL be sampled only at capture edges; changes at any other time SHALL NOT affect disp_data.
REQ-022 A requester SHALL hold req until its ack; the block SHALL treat a dropped req as withdrawn, with no memory of it.
REQ-023 The value captured SHALL be passed through unmodified, including the sign bit; negation is the display driver's job.
REQ-024 ack SHALL never have more than one bit set, and SHALL be high only in the cycle after the capture edge.

Reset
REQ-025 While rst is high, the block SHALL force: grant=0, ack=0, busy=0, disp_data=0, disp_sel=0, counter=0, round-robin pointer=3 (so requester 0 wins first), state=IDLE.
REQ-026 rst SHALL take precedence over every event, including mid-dwell and capture edges; no ack SHALL be issued in the reset cycle.

Configuration
REQ-027 Macro XDISP_CTRL_PRIO_EN, when defined, SHALL make requester 0 pre-emptive.
REQ-028 With the macro defined, req[0] high during DWELL of another owner SHALL abort the dwell at the next edge and capture requester 0 per REQ-013.
REQ-029 With the macro defined, requester 0's own dwell SHALL NOT be pre-emptible, and pre-emption SHALL NOT advance the round-robin pointer.
REQ-030 Without the macro, requester 0 SHALL be an ordinary round-robin participant and no pre-emption logic SHALL exist.

Structure
REQ-031 Shared package xdisp_pkg SHALL hold N_REQ, DATA_W=11 and the FSM state typedef.
REQ-032 Round-robin winner selection SHALL be a combinational sub-module xdisp_rr_arb (inputs: req, pointer; outputs: one-hot winner, valid).

Verification (DWELL=4)
REQ-033 Reset, then req=0001 with slice0=11'h005 -> next cycle: grant=0001, ack=0001 for one cycle, disp_data=005, disp_sel=1, busy=1; IDLE reached 4 cycles after the capture.
REQ-034 All four req held high -> grants 0001,0010,0100,1000,0001, each lasting exactly 4 cycles, disp_sel toggling at each change.
REQ-035 Requester 2 alone with slice2=11'h7FF (-1) -> disp_data=7FF; changing slice2 mid-dwell leaves disp_data unchanged until the re-grant.
REQ-036 rst pulsed during the 2nd dwell cycle -> the next cycle shows all outputs at their reset values; the first post-reset grant goes to requester 0.
REQ-037 With XDISP_CTRL_PRIO_EN, requester 1 owning and req[0] rising in its 1st dwell cycle -> grant=0001 the cycle after; requester 1 is re-granted afterwards.
REQ-038 req pulse dropped before capture (DWELL expiry) -> no ack issued and no grant for that requester.
